video_pattern_gen: RTL and testbench

Parametrised video timing and test-pattern generator for the ADV7511 HDMI path. It is the next generation of the fixed 640x480 `video_send` stage. Timing is set by parameters. Output is 16-bit YCbCr 4:2:2 with four selectable patterns, a grayscale override, a frame-start strobe and a frame counter. It runs in the pixel-clock domain and starts once `hdmi_config` reports `config_ok`.

---
 rtl/video_pattern_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator producing 16-bit YCbCr 4:2:2 for an HDMI
// transmitter. Timing comes from parameters. It starts once the transmitter reports it
// is configured and drops back to idle whenever that indication goes away.
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CHK_LOG2  = 5,
    parameter int unsigned CNT_W     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_config_ok,
    input  logic [1:0]  i_mode,
    input  logic        i_grayscale,
    output logic        o_hdmi_vsync,
    output logic        o_hdmi_hsync,
    output logic        o_hdmi_de,
    output logic [15:0] o_hdmi_data,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [15:0] BLANK_DATA = 16'h1080;
    localparam logic [7:0]  Y_WHITE    = 8'd235;
    localparam logic [7:0]  Y_BLACK    = 8'd16;
    localparam logic [7:0]  C_NEUTRAL  = 8'h80;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             run;
    logic             first_pix;

    logic [1:0]       mode_q, mode_eff;
    logic             gray_q, gray_eff;

    logic [2:0]       bar_idx;
    logic [23:0]      bar_ycc;
    logic [7:0]       line_val;
    logic [7:0]       pix_y, pix_cb, pix_cr, pix_c;
    logic             de_c, hs_c, vs_c;
    logic [15:0]      data_c;

    logic             vsync_q, hsync_q, de_q, frame_start_q;
    logic [15:0]      data_q;
    logic [7:0]       frame_cnt_q;

    // Counting only happens while the transmitter stays configured in RUN; a drop of
    // i_config_ok takes effect on the very next edge.
    assign run       = (state_q == StRun) && i_config_ok;
    assign first_pix = (h_cnt == '0) && (v_cnt == '0);

    // Mode and grayscale are latched at the frame origin; pixel (0,0) already uses
    // the freshly sampled values.
    assign mode_eff = first_pix ? i_mode : mode_q;
    assign gray_eff = first_pix ? i_grayscale : gray_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: idle until configured, back to idle as soon as it is lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (i_config_ok)  state_d = StRun;
            StRun:   if (!i_config_ok) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Raster counters: h wraps every line, v advances on h wrap and wraps per frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
            end else begin
                h_cnt <= h_cnt + CNT_ONE;
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    // Per-frame pattern controls, captured at the frame origin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q <= 2'd0;
            gray_q <= 1'b0;
        end else if (run && first_pix) begin
            mode_q <= i_mode;
            gray_q <= i_grayscale;
        end
    end

    // Bar index by comparison against constant bar edges instead of a divider.
    always_comb begin
        bar_idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_cnt >= CNT_W'(k * BAR_W)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    // BT.601 colour-bar table, packed as {Y, Cb, Cr}.
    always_comb begin
        bar_ycc = {Y_BLACK, C_NEUTRAL, C_NEUTRAL};
        case (bar_idx)
            3'd0:    bar_ycc = {8'd235, 8'd128, 8'd128};
            3'd1:    bar_ycc = {8'd210, 8'd16,  8'd146};
            3'd2:    bar_ycc = {8'd170, 8'd166, 8'd16};
            3'd3:    bar_ycc = {8'd145, 8'd54,  8'd34};
            3'd4:    bar_ycc = {8'd106, 8'd202, 8'd222};
            3'd5:    bar_ycc = {8'd81,  8'd90,  8'd240};
            3'd6:    bar_ycc = {8'd41,  8'd240, 8'd110};
            default: bar_ycc = {8'd16,  8'd128, 8'd128};
        endcase
    end

    // Moving-line column matches the frame count shown alongside the pixel; at the
    // frame origin the counter is about to step, so compare against the stepped value.
    assign line_val = first_pix ? (frame_cnt_q + 8'd1) : frame_cnt_q;

    // Pattern generation and timing decode for the current counter position.
    always_comb begin
        pix_y  = Y_BLACK;
        pix_cb = C_NEUTRAL;
        pix_cr = C_NEUTRAL;
        case (mode_eff)
            2'd0: begin
                pix_y  = bar_ycc[23:16];
                pix_cb = bar_ycc[15:8];
                pix_cr = bar_ycc[7:0];
            end
            2'd1: pix_y = h_cnt[7:0];
            2'd2: pix_y = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? Y_WHITE : Y_BLACK;
            default: pix_y = (h_cnt[7:0] == line_val) ? Y_WHITE : Y_BLACK;
        endcase

        // Chroma phase restarts each line since h_cnt does.
        pix_c = h_cnt[0] ? pix_cr : pix_cb;
        if (gray_eff) begin
            pix_c = C_NEUTRAL;
        end

        de_c   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        data_c = de_c ? {pix_y, pix_c} : BLANK_DATA;
        hs_c   = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_c   = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Output registers: one cycle behind the counters, forced to idle values when not
    // running. The frame counter survives idle and is cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vsync_q       <= ~VSYNC_POL;
            hsync_q       <= ~HSYNC_POL;
            de_q          <= 1'b0;
            data_q        <= BLANK_DATA;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else if (run) begin
            vsync_q       <= vs_c;
            hsync_q       <= hs_c;
            de_q          <= de_c;
            data_q        <= data_c;
            frame_start_q <= first_pix;
            if (first_pix) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end else begin
            vsync_q       <= ~VSYNC_POL;
            hsync_q       <= ~HSYNC_POL;
            de_q          <= 1'b0;
            data_q        <= BLANK_DATA;
            frame_start_q <= 1'b0;
        end
    end

    assign o_hdmi_vsync  = vsync_q;
    assign o_hdmi_hsync  = hsync_q;
    assign o_hdmi_de     = de_q;
    assign o_hdmi_data   = data_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a small raster. A flat time-index model predicts every
// output on every cycle; stimulus randomises mode, grayscale and configuration drops.
module tb_video_pattern_gen;

    localparam int HA = 16, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4,  VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int CHK = 1;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg;
    logic [1:0]  mode;
    logic        gray;
    logic        o_vs, o_hs, o_de, o_fs;
    logic [15:0] o_data;
    logic [7:0]  o_fc;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .CHK_LOG2(CHK), .CNT_W(8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_config_ok  (cfg),
        .i_mode       (mode),
        .i_grayscale  (gray),
        .o_hdmi_vsync (o_vs),
        .o_hdmi_hsync (o_hs),
        .o_hdmi_de    (o_de),
        .o_hdmi_data  (o_data),
        .o_frame_start(o_fs),
        .o_frame_cnt  (o_fc)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int bar_y [8] = '{235, 210, 170, 145, 106, 81, 41, 16};
    int bar_cb[8] = '{128, 16, 166, 54, 202, 90, 240, 128};
    int bar_cr[8] = '{128, 146, 16, 34, 222, 240, 110, 128};

    // Model state: running flag, position index within the frame, frame count and the
    // controls captured for the current frame.
    bit m_run  = 1'b0;
    int m_t    = 0;
    int m_fcnt = 0;
    int m_mode = 0;
    bit m_gray = 1'b0;

    logic        e_vs, e_hs, e_de, e_fs;
    logic [15:0] e_data;
    logic [7:0]  e_fc;

    function automatic logic [15:0] pix(int x, int y, int md, bit gr, int fc);
        int yy, cb, cr, idx;
        if (x >= HA || y >= VA) return 16'h1080;
        cb = 128;
        cr = 128;
        case (md)
            0: begin
                idx = x / (HA / 8);
                yy  = bar_y[idx];
                cb  = bar_cb[idx];
                cr  = bar_cr[idx];
            end
            1: yy = x % 256;
            2: yy = (((x >> CHK) ^ (y >> CHK)) & 1) ? 235 : 16;
            default: yy = ((x % 256) == fc) ? 235 : 16;
        endcase
        if (gr) begin
            cb = 128;
            cr = 128;
        end
        return {8'(yy), 8'((x % 2) ? cr : cb)};
    endfunction

    task automatic expect_idle();
        e_vs   = ~VP;
        e_hs   = ~HP;
        e_de   = 1'b0;
        e_data = 16'h1080;
        e_fs   = 1'b0;
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".vsync"}, 16'(o_vs), 16'(e_vs));
        check({tag, ".hsync"}, 16'(o_hs), 16'(e_hs));
        check({tag, ".de"}, 16'(o_de), 16'(e_de));
        check({tag, ".data"}, o_data, e_data);
        check({tag, ".frame_start"}, 16'(o_fs), 16'(e_fs));
        check({tag, ".frame_cnt"}, 16'(o_fc), 16'(e_fc));
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_t    = 0;
        m_fcnt = 0;
        m_mode = 0;
        m_gray = 1'b0;
        expect_idle();
        e_fc = 8'd0;
    endtask

    // Predict the outputs after the coming edge from the inputs now applied, then
    // clock once and compare just after the edge.
    task automatic step(string tag);
        int x, y;
        if (rst) begin
            model_reset();
        end else if (m_run && cfg) begin
            x    = m_t % HT;
            y    = m_t / HT;
            e_fs = (x == 0 && y == 0);
            if (e_fs) begin
                m_mode = int'(mode);
                m_gray = gray;
                m_fcnt = (m_fcnt + 1) % 256;
            end
            e_hs   = (x >= HA + HF && x < HA + HF + HSW) ? HP : ~HP;
            e_vs   = (y >= VA + VF && y < VA + VF + VSW) ? VP : ~VP;
            e_de   = (x < HA) && (y < VA);
            e_data = pix(x, y, m_mode, m_gray, m_fcnt);
            e_fc   = 8'(m_fcnt);
            m_t    = (m_t + 1) % FRAME;
        end else begin
            expect_idle();
            m_run = cfg;
            m_t   = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_controls(int odds);
        if ($urandom_range(odds - 1, 0) == 0) begin
            mode = 2'($urandom);
            gray = 1'($urandom);
        end
    endtask

    initial begin
        rst  = 1'b1;
        cfg  = 1'b0;
        mode = 2'd0;
        gray = 1'b0;

        // Asynchronous reset before any clock edge.
        #1;
        model_reset();
        check_all("reset_async");
        repeat (3) step("reset_held");
        rst = 1'b0;
        repeat (4) step("idle");

        // Colour bars, fixed controls, three frames plus the start-up edge.
        cfg = 1'b1;
        repeat (3 * FRAME + 2) step("bars");

        // Controls change at random, including mid-frame; sampled only at frame start.
        for (int i = 0; i < 20 * FRAME; i++) begin
            rand_controls(16);
            step("rand_mode");
        end

        // Configuration dropped and restored at random points.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(400, 30)) begin
                rand_controls(32);
                step("drop_run");
            end
            cfg = 1'b0;
            repeat ($urandom_range(5, 1)) step("drop_idle");
            cfg = 1'b1;
        end

        // Reset asserted between edges while running.
        repeat (100) step("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_midrun");
        step("reset_midrun_held");
        rst = 1'b0;

        // Long run so the frame counter wraps 255 -> 0.
        for (int i = 0; i < 262 * FRAME; i++) begin
            rand_controls(64);
            step("wrap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
